aes_rcon_gen: RTL and testbench



---
 rtl/aes_rcon_gen_pkg.sv | 13 +
 rtl/aes_rcon_gen_if.sv | 17 +
 rtl/aes_rcon_gen_lut.sv | 11 +
 rtl/aes_rcon_gen.sv | 33 +++
 tb/tb_aes_rcon_gen.sv | 112 +++++++++++
 5 files changed

// File: rtl/aes_rcon_gen_pkg.sv
// aes_pkg: shared widths, the AES round-constant byte table and word helper
package aes_pkg;
   localparam int RCON_W = 32;
   localparam int CNT_W  = 4;
   // entry i holds the Rcon byte for round index i; 10..15 are zero
   localparam logic [15:0][7:0] RCON_TAB = {
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h36, 8'h1B,
      8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
   };
   function automatic logic [RCON_W-1:0] rcon_word(input logic [CNT_W-1:0] idx);
      return {RCON_TAB[idx], 24'h000000};
   endfunction
endpackage

// File: rtl/aes_rcon_gen_if.sv
// aes_rcon_gen_if: key-load request and round-constant result bundle
//   kld   : key load, restarts the Rcon sequence
//   out   : current round constant {rcon_byte, 24'h0}
//   round : current round index (only with AES_RCON_ROUND_OUT_EN)
interface aes_rcon_gen_if;
   import aes_pkg::*;
   logic              kld;
   logic [RCON_W-1:0] out;
`ifdef AES_RCON_ROUND_OUT_EN
   logic [CNT_W-1:0]  round;
   modport master (output kld, input out, input round);
   modport slave  (input kld, output out, output round);
`else
   modport master (output kld, input out);
   modport slave  (input kld, output out);
`endif
endinterface

// File: rtl/aes_rcon_gen_lut.sv
// aes_rcon_lut: combinational round index to Rcon word mapping
//   idx  : round index
//   word : {RCON_TAB[idx], 24'h0}
module aes_rcon_lut
   import aes_pkg::*;
(
   input  logic [CNT_W-1:0]  idx,
   output logic [RCON_W-1:0] word
);
   assign word = rcon_word(idx);
endmodule

// File: rtl/aes_rcon_gen.sv
// aes_rcon_gen: registered AES key-expansion round-constant sequencer
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of aes_rcon_gen_if (kld in, out / round out)
// Optional: define AES_RCON_ROUND_OUT_EN to expose the round counter on bus.round
module aes_rcon_gen
   import aes_pkg::*;
(
   input logic           clk,
   input logic           rst_n,
   aes_rcon_gen_if.slave bus
);
   logic [CNT_W-1:0]  rcnt;
   logic [CNT_W-1:0]  rcnt_nxt;
   logic [RCON_W-1:0] out_nxt;
   logic [RCON_W-1:0] out_q;
   // look up the following entry so out stays aligned with rcnt after the edge
   assign rcnt_nxt = rcnt + 4'd1;
   aes_rcon_lut u_lut (.idx(rcnt_nxt), .word(out_nxt));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rcnt  <= '0;
         out_q <= rcon_word('0);
      end else begin
         rcnt  <= bus.kld ? '0 : rcnt_nxt;
         out_q <= bus.kld ? rcon_word('0) : out_nxt;
      end
   end
   assign bus.out = out_q;
`ifdef AES_RCON_ROUND_OUT_EN
   assign bus.round = rcnt;
`endif
endmodule

// File: tb/tb_aes_rcon_gen.sv
// tb_aes_rcon_gen: directed and random-kld checks of aes_rcon_gen against a table model
module tb_aes_rcon_gen;
   logic clk = 1'b0;
   logic rst_n;
   int   nvec = 0;
   int   nerr = 0;
   logic [3:0] m;
   logic       k;

   aes_rcon_gen_if bus ();
   aes_rcon_gen dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   function automatic logic [31:0] exp_word(input logic [3:0] i);
      case (i)
         4'd0: return 32'h01000000;
         4'd1: return 32'h02000000;
         4'd2: return 32'h04000000;
         4'd3: return 32'h08000000;
         4'd4: return 32'h10000000;
         4'd5: return 32'h20000000;
         4'd6: return 32'h40000000;
         4'd7: return 32'h80000000;
         4'd8: return 32'h1B000000;
         4'd9: return 32'h36000000;
         default: return 32'h00000000;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [3:0] idx);
      nvec++;
      assert (bus.out === exp_word(idx)) else begin
         nerr++;
         $error("FAIL %s: out=%h expected=%h", tag, bus.out, exp_word(idx));
      end
`ifdef AES_RCON_ROUND_OUT_EN
      nvec++;
      assert (bus.round === idx) else begin
         nerr++;
         $error("FAIL %s_round: round=%h expected=%h", tag, bus.round, idx);
      end
`endif
   endtask

   task automatic cyc(input logic kv);
      @(negedge clk);
      bus.kld = kv;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n   = 1'b0;
      bus.kld = 1'b0;
      #12;
      chk("reset", 4'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("reset_release", 4'd1);
      cyc(1'b1);
      chk("load", 4'd0);
      for (int i = 1; i <= 20; i++) begin
         cyc(1'b0);
         chk("free_run", 4'(i));
      end
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1);
         chk("kld_held", 4'd0);
      end
      cyc(1'b0);
      chk("kld_drop", 4'd1);
      for (int i = 2; i <= 7; i++) begin
         cyc(1'b0);
         chk("to_80", 4'(i));
      end
      cyc(1'b1);
      chk("mid_reload", 4'd0);
      cyc(1'b0);
      chk("after_reload", 4'd1);
      for (int i = 2; i <= 8; i++) begin
         cyc(1'b0);
         chk("to_1b", 4'(i));
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset", 4'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("async_release", 4'd1);
      cyc(1'b0);
      chk("async_resume", 4'd2);
      m = 4'd2;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         chk("rand_neg", m);
         k = ($urandom_range(0, 9) == 0);
         bus.kld = k;
         @(posedge clk);
         #1;
         m = k ? 4'd0 : m + 4'd1;
         chk("rand_pos", m);
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
